// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  // Datapath -> controller
  logic [5:0]       OpCode;
  logic [5:0]       funct;
  logic             Zero;
  logic             dm_rdy;

  // Controller -> datapath
  logic             PCWr;
  logic [2:0]       PcSel;
  logic             IRWr;
  logic             RegW;
  logic             RegDst;
  logic             Mem2R;
  logic             MemW;
  logic             Alusrc;
  logic             shift;
  logic [1:0]       ExtOp;
  logic [4:0]       Aluctrl;
  logic [3:0]       state;
  logic             ill_op;
  logic [CNT_W-1:0] ret_cnt;

  modport master (
    input  OpCode, funct, Zero, dm_rdy,
    output PCWr, PcSel, IRWr, RegW, RegDst, Mem2R, MemW, Alusrc, shift,
           ExtOp, Aluctrl, state, ill_op, ret_cnt
  );

  modport slave (
    output OpCode, funct, Zero, dm_rdy,
    input  PCWr, PcSel, IRWr, RegW, RegDst, Mem2R, MemW, Alusrc, shift,
           ExtOp, Aluctrl, state, ill_op, ret_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB, drives every datapath
// enable and select, counts retired instructions and flags illegal opcodes.
module mc_ctrl #(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXE  = 4'd2,
    S_MADR = 4'd3,
    S_MRD  = 4'd4,
    S_MWR  = 4'd5,
    S_WB   = 4'd6,
    S_BR   = 4'd7,
    S_JMP  = 4'd8
  } state_e;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_SLT = 5'd4,
    ALU_SLL = 5'd5,
    ALU_SRL = 5'd6,
    ALU_LUI = 5'd7
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;

  localparam logic [2:0] PC_SEQ = 3'd0;
  localparam logic [2:0] PC_BR  = 3'd1;
  localparam logic [2:0] PC_JMP = 3'd4;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HI16 = 2'd2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  // Opcode decode; IR holds OpCode/funct stable outside IF, so every state decodes live.
  logic op_rtype, op_ori, op_addiu, op_lui, op_lw, op_sw, op_beq, op_bne, op_j;
  logic funct_ok, is_alu;

  assign op_rtype = (bus.OpCode == OP_RTYPE);
  assign op_ori   = (bus.OpCode == OP_ORI);
  assign op_addiu = (bus.OpCode == OP_ADDIU);
  assign op_lui   = (bus.OpCode == OP_LUI);
  assign op_lw    = (bus.OpCode == OP_LW);
  assign op_sw    = (bus.OpCode == OP_SW);
  assign op_beq   = (bus.OpCode == OP_BEQ);
  assign op_bne   = (bus.OpCode == OP_BNE);
  assign op_j     = (bus.OpCode == OP_J);

  // ALU-class datapath selects shared by EXE and the WB that follows it.
  alu_op_e    exe_alu;
  logic       exe_src;
  logic [1:0] exe_ext;
  logic       exe_shift;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    exe_alu   = ALU_ADD;
    exe_src   = 1'b0;
    exe_ext   = EXT_ZERO;
    exe_shift = 1'b0;
    funct_ok  = 1'b0;
    if (op_rtype) begin
      funct_ok = 1'b1;
      unique case (bus.funct)
        FN_ADDU: exe_alu = ALU_ADD;
        FN_SUBU: exe_alu = ALU_SUB;
        FN_AND:  exe_alu = ALU_AND;
        FN_OR:   exe_alu = ALU_OR;
        FN_SLT:  exe_alu = ALU_SLT;
        FN_SLL: begin
          exe_alu   = ALU_SLL;
          exe_shift = 1'b1;
        end
        FN_SRL: begin
          exe_alu   = ALU_SRL;
          exe_shift = 1'b1;
        end
        default: funct_ok = 1'b0;
      endcase
    end else if (op_ori) begin
      exe_alu = ALU_OR;
      exe_src = 1'b1;
      exe_ext = EXT_ZERO;
    end else if (op_addiu) begin
      exe_alu = ALU_ADD;
      exe_src = 1'b1;
      exe_ext = EXT_SIGN;
    end else if (op_lui) begin
      exe_alu = ALU_LUI;
      exe_src = 1'b1;
      exe_ext = EXT_HI16;
    end
  end

  assign is_alu = (op_rtype && funct_ok) || op_ori || op_addiu || op_lui;

  // With waiting disabled, memory states always complete in a single cycle.
  logic mem_done;
  assign mem_done = (MEM_WAIT_EN == 1'b0) || bus.dm_rdy;

  logic       pc_wr, ir_wr, reg_w, mem_w, ill;
  logic [2:0] pc_sel;
  logic       reg_dst, mem2r, alu_src, alu_shift;
  logic [1:0] ext_op;
  alu_op_e    alu_ctrl;
  logic       retire;

  always_comb begin
    state_d   = S_IF;
    pc_wr     = 1'b0;
    pc_sel    = PC_SEQ;
    ir_wr     = 1'b0;
    reg_w     = 1'b0;
    reg_dst   = 1'b0;
    mem2r     = 1'b0;
    mem_w     = 1'b0;
    alu_src   = 1'b0;
    alu_shift = 1'b0;
    ext_op    = EXT_ZERO;
    alu_ctrl  = ALU_ADD;
    ill       = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_IF: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_alu)               state_d = S_EXE;
        else if (op_lw || op_sw)  state_d = S_MADR;
        else if (op_beq || op_bne) state_d = S_BR;
        else if (op_j)            state_d = S_JMP;
        else begin
          ill     = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXE: begin
        alu_ctrl  = exe_alu;
        alu_src   = exe_src;
        ext_op    = exe_ext;
        alu_shift = exe_shift;
        state_d   = S_WB;
      end
      S_MADR: begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b1;
        ext_op   = EXT_SIGN;
        state_d  = op_lw ? S_MRD : S_MWR;
      end
      S_MRD: begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b1;
        ext_op   = EXT_SIGN;
        state_d  = mem_done ? S_WB : S_MRD;
      end
      S_MWR: begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b1;
        ext_op   = EXT_SIGN;
        mem_w    = 1'b1;
        if (mem_done) begin
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_MWR;
        end
      end
      S_WB: begin
        reg_w   = 1'b1;
        reg_dst = op_rtype;
        mem2r   = op_lw;
        if (op_lw) begin
          alu_ctrl = ALU_ADD;
          alu_src  = 1'b1;
          ext_op   = EXT_SIGN;
        end else begin
          alu_ctrl  = exe_alu;
          alu_src   = exe_src;
          ext_op    = exe_ext;
          alu_shift = exe_shift;
        end
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_BR: begin
        alu_ctrl = ALU_SUB;
        alu_src  = 1'b0;
        pc_sel   = PC_BR;
        pc_wr    = (op_beq && bus.Zero) || (op_bne && !bus.Zero);
        retire   = 1'b1;
        state_d  = S_IF;
      end
      S_JMP: begin
        pc_wr   = 1'b1;
        pc_sel  = PC_JMP;
        retire  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign ret_cnt_d = retire ? ret_cnt_q + 1'b1 : ret_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IF;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Enables are masked by reset so they fall the instant rst drops, even though
  // the reset state itself (IF) would otherwise assert PCWr/IRWr.
  assign bus.PCWr    = pc_wr && rst;
  assign bus.IRWr    = ir_wr && rst;
  assign bus.RegW    = reg_w && rst;
  assign bus.MemW    = mem_w && rst;
  assign bus.ill_op  = ill && rst;
  assign bus.PcSel   = rst ? pc_sel    : PC_SEQ;
  assign bus.RegDst  = rst ? reg_dst   : 1'b0;
  assign bus.Mem2R   = rst ? mem2r     : 1'b0;
  assign bus.Alusrc  = rst ? alu_src   : 1'b0;
  assign bus.shift   = rst ? alu_shift : 1'b0;
  assign bus.ExtOp   = rst ? ext_op    : EXT_ZERO;
  assign bus.Aluctrl = rst ? alu_ctrl  : ALU_ADD;
  assign bus.state   = state_q;
  assign bus.ret_cnt = ret_cnt_q;

endmodule
